// File: rtl/uart_axi_lite_master.sv
// UART-to-AXI4-Lite bridge: parses command frames from the UART rx byte stream,
// issues one AXI4-Lite read or write, and returns status (+ read data) on the tx stream.
//
// state   | meaning
// S_IDLE  | waiting for a command byte (0xA5 write, 0x5A read)
// S_ADDR  | shifting in address bytes, MSB first
// S_WDATA | shifting in 4 write data bytes, MSB first
// S_WR    | AW and W channels outstanding
// S_WB    | waiting for write response
// S_RA    | AR channel outstanding
// S_RD    | waiting for read data
// S_TX    | sending status byte and read data bytes
module uart_axi_lite_master #(
  parameter int P_M_AXI_DATA_WIDTH = 32,
  parameter int P_M_AXI_ADDR_WIDTH = 16,
  parameter int P_UART_DATA_WIDTH  = 8,
  parameter int P_RX_TIMEOUT       = 1_000_000
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic                          i_user_rx_valid,
  input  logic [P_UART_DATA_WIDTH-1:0]  i_user_rx_data,
  output logic                          o_user_tx_valid,
  output logic [P_UART_DATA_WIDTH-1:0]  o_user_tx_data,
  input  logic                          i_user_tx_ready
);

  localparam int NA = P_M_AXI_ADDR_WIDTH / 8;
  localparam int TW = $clog2(P_RX_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(P_RX_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(1);
  localparam logic [P_UART_DATA_WIDTH-1:0] CMD_WR = 8'hA5;
  localparam logic [P_UART_DATA_WIDTH-1:0] CMD_RD = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WR, S_WB, S_RA, S_RD, S_TX
  } state_t;

  state_t                          state;
  logic                            is_read;
  logic [3:0]                      byte_cnt;
  logic [TW-1:0]                   to_cnt;
  logic [P_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [P_M_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [2:0]                      tx_left;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state           <= S_IDLE;
      is_read         <= 1'b0;
      byte_cnt        <= '0;
      to_cnt          <= '0;
      addr_q          <= '0;
      m_axi_wdata     <= '0;
      rdata_q         <= '0;
      tx_left         <= '0;
      m_axi_awvalid   <= 1'b0;
      m_axi_wvalid    <= 1'b0;
      m_axi_bready    <= 1'b0;
      m_axi_arvalid   <= 1'b0;
      m_axi_rready    <= 1'b0;
      o_user_tx_valid <= 1'b0;
      o_user_tx_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_user_rx_valid && (i_user_rx_data == CMD_WR || i_user_rx_data == CMD_RD)) begin
            is_read  <= (i_user_rx_data == CMD_RD);
            byte_cnt <= '0;
            to_cnt   <= TO_LOAD;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (i_user_rx_valid) begin
            addr_q <= P_M_AXI_ADDR_WIDTH'({addr_q, i_user_rx_data});
            to_cnt <= TO_LOAD;
            if (byte_cnt == 4'(NA - 1)) begin
              byte_cnt <= '0;
              if (is_read) begin
                m_axi_arvalid <= 1'b1;
                state         <= S_RA;
              end else begin
                state <= S_WDATA;
              end
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end else if (to_cnt == TO_LAST) begin
            to_cnt   <= '0;
            byte_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            to_cnt <= to_cnt - TO_LAST;
          end
        end
        S_WDATA: begin
          if (i_user_rx_valid) begin
            m_axi_wdata <= {m_axi_wdata[P_M_AXI_DATA_WIDTH-9:0], i_user_rx_data};
            to_cnt      <= TO_LOAD;
            if (byte_cnt == 4'd3) begin
              byte_cnt      <= '0;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= S_WR;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end else if (to_cnt == TO_LAST) begin
            to_cnt   <= '0;
            byte_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            to_cnt <= to_cnt - TO_LAST;
          end
        end
        S_WR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          // Each channel is done if it already handshook or handshakes now.
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= S_WB;
          end
        end
        S_WB: begin
          if (m_axi_bvalid) begin
            m_axi_bready    <= 1'b0;
            o_user_tx_valid <= 1'b1;
            o_user_tx_data  <= {{(P_UART_DATA_WIDTH-2){1'b0}}, m_axi_bresp};
            tx_left         <= 3'd0;
            state           <= S_TX;
          end
        end
        S_RA: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_RD;
          end
        end
        S_RD: begin
          if (m_axi_rvalid) begin
            m_axi_rready    <= 1'b0;
            rdata_q         <= m_axi_rdata;
            o_user_tx_valid <= 1'b1;
            o_user_tx_data  <= {{(P_UART_DATA_WIDTH-2){1'b0}}, m_axi_rresp};
            tx_left         <= 3'd4;
            state           <= S_TX;
          end
        end
        S_TX: begin
          if (i_user_tx_ready) begin
            if (tx_left == 3'd0) begin
              o_user_tx_valid <= 1'b0;
              state           <= S_IDLE;
            end else begin
              o_user_tx_data <= rdata_q[P_M_AXI_DATA_WIDTH-1 -: 8];
              rdata_q        <= {rdata_q[P_M_AXI_DATA_WIDTH-9:0], 8'h00};
              tx_left        <= tx_left - 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axi_lite_master.sv
// Scoreboard bench for uart_axi_lite_master: frames are driven on the rx stream,
// a randomized AXI slave answers, and tx bytes are checked against queued expectations.
module tb_uart_axi_lite_master;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready = 1'b0;
  logic [1:0]  bresp = 2'd0;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rvalid = 1'b0, rready;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  uart_axi_lite_master #(
    .P_M_AXI_DATA_WIDTH(32), .P_M_AXI_ADDR_WIDTH(16),
    .P_UART_DATA_WIDTH(8), .P_RX_TIMEOUT(TO)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .i_user_rx_valid(rx_valid), .i_user_rx_data(rx_data),
    .o_user_tx_valid(tx_valid), .o_user_tx_data(tx_data), .i_user_tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
  logic [7:0]  exp_tx[$];
  logic [1:0]  cfg_bresp = 2'd0, cfg_rresp = 2'd0;
  logic [31:0] cfg_rdata = 32'd0;
  bit          stall = 1'b0;
  bit          tx_toggle = 1'b0;
  int          b_count = 0, r_count = 0, aw_count = 0, ar_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AW slave
  initial forever begin
    @(negedge clk);
    if (rst_n && !stall && awvalid) begin
      aw_count++;
      if (exp_aw.size() > 0) chk("awaddr", {16'h0, awaddr}, exp_aw.pop_front());
      else chk("aw_unexpected", exp_aw.size(), 1);
      chk("awprot", {29'h0, awprot}, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("aw_hold", {31'h0, awvalid}, 1);
      awready = 1'b1;
      @(negedge clk);
      awready = 1'b0;
    end
  end

  // W slave
  initial forever begin
    @(negedge clk);
    if (rst_n && !stall && wvalid) begin
      if (exp_w.size() > 0) chk("wdata", wdata, exp_w.pop_front());
      else chk("w_unexpected", exp_w.size(), 1);
      chk("wstrb", {28'h0, wstrb}, 32'hF);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("w_hold", {31'h0, wvalid}, 1);
      wready = 1'b1;
      @(negedge clk);
      wready = 1'b0;
    end
  end

  // B slave
  initial forever begin
    @(negedge clk);
    if (rst_n && bready) begin
      bvalid = 1'b1;
      bresp  = cfg_bresp;
      @(negedge clk);
      bvalid = 1'b0;
      b_count++;
      chk("bready_drop", {31'h0, bready}, 0);
    end
  end

  // AR slave
  initial forever begin
    @(negedge clk);
    if (rst_n && !stall && arvalid) begin
      ar_count++;
      if (exp_ar.size() > 0) chk("araddr", {16'h0, araddr}, exp_ar.pop_front());
      else chk("ar_unexpected", exp_ar.size(), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("ar_hold", {31'h0, arvalid}, 1);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
    end
  end

  // R slave
  initial forever begin
    @(negedge clk);
    if (rst_n && rready) begin
      rvalid = 1'b1;
      rdata  = cfg_rdata;
      rresp  = cfg_rresp;
      @(negedge clk);
      rvalid = 1'b0;
      r_count++;
      chk("rready_drop", {31'h0, rready}, 0);
    end
  end

  // tx consumer: handshake happens on the posedge following a negedge with ready high
  initial begin
    logic [7:0] last_data;
    bit         last_pending;
    last_data    = 8'h0;
    last_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_ready     = 1'b0;
        last_pending = 1'b0;
      end else begin
        tx_ready = tx_toggle ? ~tx_ready : 1'b1;
        if (tx_valid) begin
          if (last_pending) chk("tx_hold", {24'h0, tx_data}, {24'h0, last_data});
          if (tx_ready) begin
            if (exp_tx.size() > 0) chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
            else chk("tx_unexpected", exp_tx.size(), 1);
            last_pending = 1'b0;
          end else begin
            last_pending = 1'b1;
            last_data    = tx_data;
          end
        end else begin
          last_pending = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_write(input logic [15:0] a, input logic [31:0] d, input logic [1:0] resp, input int gap);
    cfg_bresp = resp;
    exp_aw.push_back({16'h0, a});
    exp_w.push_back(d);
    exp_tx.push_back({6'h0, resp});
    send_byte(8'hA5, gap);
    send_byte(a[15:8], gap);
    send_byte(a[7:0], gap);
    send_byte(d[31:24], gap);
    send_byte(d[23:16], gap);
    send_byte(d[15:8], gap);
    send_byte(d[7:0], gap);
    chk("aw_latency", {31'h0, awvalid}, 1);
  endtask

  task automatic send_read(input logic [15:0] a, input logic [31:0] d, input logic [1:0] resp);
    cfg_rdata = d;
    cfg_rresp = resp;
    exp_ar.push_back({16'h0, a});
    exp_tx.push_back({6'h0, resp});
    exp_tx.push_back(d[31:24]);
    exp_tx.push_back(d[23:16]);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
    send_byte(8'h5A, 0);
    send_byte(a[15:8], 0);
    send_byte(a[7:0], 0);
    chk("ar_latency", {31'h0, arvalid}, 1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_aw.size() + exp_w.size() + exp_ar.size() + exp_tx.size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'h0, n < 2000}, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int b0, r0, aw0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", {31'h0, awvalid}, 0);
    chk("rst_wvalid", {31'h0, wvalid}, 0);
    chk("rst_arvalid", {31'h0, arvalid}, 0);
    chk("rst_bready", {31'h0, bready}, 0);
    chk("rst_rready", {31'h0, rready}, 0);
    chk("rst_txvalid", {31'h0, tx_valid}, 0);
    chk("rst_awaddr", {16'h0, awaddr}, 0);
    chk("rst_araddr", {16'h0, araddr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_txdata", {24'h0, tx_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    b0 = b_count;
    send_write(16'h0010, 32'hDEADBEEF, 2'd0, 0);
    wait_done("wr_basic");
    chk("wr_basic_b", b_count - b0, 1);

    tx_toggle = 1'b1;
    r0 = r_count;
    send_read(16'h0020, 32'h12345678, 2'd0);
    wait_done("rd_toggle");
    chk("rd_toggle_r", r_count - r0, 1);
    tx_toggle = 1'b0;

    b0 = b_count;
    send_write(16'h1234, 32'hA5A55A5A, 2'd2, TO - 4);
    wait_done("wr_slverr");
    chk("wr_slverr_b", b_count - b0, 1);

    send_read(16'hBEEF, 32'hCAFEF00D, 2'd3);
    wait_done("rd_decerr");

    r0 = r_count;
    b0 = b_count;
    send_byte(8'h33, 0);
    send_byte(8'hFF, 0);
    send_read(16'h0040, 32'h0BADF00D, 2'd0);
    wait_done("junk_rd");
    chk("junk_r", r_count - r0, 1);
    chk("junk_b", b_count - b0, 0);

    aw0 = aw_count + ar_count;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    repeat (TO + 5) @(negedge clk);
    chk("to_no_axi", aw_count + ar_count - aw0, 0);
    send_read(16'h0077, 32'h00FF00FF, 2'd1);
    wait_done("to_rd");

    stall = 1'b1;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h50, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h11, 0);
    chk("rst_pre_awvalid", {31'h0, awvalid}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_awvalid", {31'h0, awvalid}, 0);
    chk("rst_mid_wvalid", {31'h0, wvalid}, 0);
    chk("rst_mid_awaddr", {16'h0, awaddr}, 0);
    chk("rst_mid_wdata", wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    @(negedge clk);
    b0 = b_count;
    send_write(16'h0100, 32'h87654321, 2'd0, 0);
    wait_done("post_rst_wr");
    chk("post_rst_b", b_count - b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
